systolic_drain: RTL and testbench

//  Output-side counterpart of the systolic input injector: collects results leaving the array edge.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/lane_fifo.sv | 64 ++++++
 rtl/systolic_drain.sv | 129 ++++++++++++
 tb/tb_systolic_drain.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults and state type for the systolic result drain
package systolic_pkg;

    localparam int N      = 32;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int ROWS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane synchronous FIFO with flush, show-ahead read
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of pointers and count (wins over push/pop)
//   push, wdata     write request; ignored while full
//   pop             read request; ignored while empty
//   rdata           word at the head (valid while !empty)
//   count/full/empty occupancy status
module lane_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A write to a full lane is dropped even if the lane pops in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - de-skews systolic array edge results into aligned output vectors
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            clears FIFOs/counters/flags and begins draining a tile
//   res_valid/res_in per-lane skewed results from the array edge
//   drain_stall      some lane is within N words of full; array must pause
//   out_valid/out_ready/out_data  aligned vector handshake toward writeback
//   vec_count        vectors accepted this tile
//   complete_flag    ROWS vectors accepted
//   overflow_err     sticky: a write hit a full lane
module systolic_drain #(
    parameter int N      = systolic_pkg::N,
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int DEPTH  = systolic_pkg::DEPTH,
    parameter int ROWS   = systolic_pkg::ROWS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [N-1:0]               res_valid,
    input  logic [DATA_W-1:0]          res_in [0:N-1],
    output logic                       drain_stall,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data [0:N-1],
    output logic [$clog2(ROWS+1)-1:0]  vec_count,
    output logic                       complete_flag,
    output logic                       overflow_err
);

    import systolic_pkg::*;

    localparam int CW = $clog2(ROWS+1);
    localparam int FW = $clog2(DEPTH) + 1;

    drain_state_t state, state_next;

    logic [N-1:0]      lane_push;
    logic [N-1:0]      lane_full;
    logic [N-1:0]      lane_empty;
    logic [DATA_W-1:0] lane_rdata [N];
    logic [FW-1:0]     lane_count [N];

    logic do_pop;
    logic accept;
    logic last_accept;
    logic room;

    // start flushes everything, so it suppresses any same-cycle write, pop or accept.
    assign lane_push   = (state == DRAIN && !start) ? res_valid : '0;
    // Vectors already accepted plus the one sitting in the output register must stay below ROWS.
    assign room        = (32'(vec_count) + 32'(out_valid)) < ROWS;
    assign do_pop      = (state == DRAIN) && !start && !(|lane_empty)
                         && (!out_valid || out_ready) && room;
    assign accept      = out_valid && out_ready && !start;
    assign last_accept = accept && (vec_count == CW'(ROWS-1));

    for (genvar i = 0; i < N; i++) begin : g_lane
        lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (start),
            .push  (lane_push[i]),
            .wdata (res_in[i]),
            .pop   (do_pop),
            .rdata (lane_rdata[i]),
            .count (lane_count[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i])
        );
    end

    // Threshold of DEPTH-N leaves room for the N cycles of skew still in flight.
    always_comb begin
        drain_stall = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (32'(lane_count[i]) >= DEPTH - N) drain_stall = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = DRAIN;
        end else begin
            case (state)
                DRAIN:   if (last_accept) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            vec_count     <= '0;
            complete_flag <= 1'b0;
            overflow_err  <= 1'b0;
            for (int i = 0; i < N; i++) out_data[i] <= '0;
        end else if (start) begin
            out_valid     <= 1'b0;
            vec_count     <= '0;
            complete_flag <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            if (do_pop) begin
                out_valid <= 1'b1;
                for (int i = 0; i < N; i++) out_data[i] <= lane_rdata[i];
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept)      vec_count     <= vec_count + 1'b1;
            if (last_accept) complete_flag <= 1'b1;
            if (|(lane_push & lane_full)) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - scoreboard bench for systolic_drain (N=4, DEPTH=16, ROWS=4)
module tb_systolic_drain;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int ROWS  = 4;
    localparam int CW    = $clog2(ROWS+1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  res_valid;
    logic [DW-1:0] res_in [0:N-1];
    logic          drain_stall;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data [0:N-1];
    logic [CW-1:0] vec_count;
    logic          complete_flag;
    logic          overflow_err;

    systolic_drain #(.N(N), .DATA_W(DW), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .res_valid     (res_valid),
        .res_in        (res_in),
        .drain_stall   (drain_stall),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .vec_count     (vec_count),
        .complete_flag (complete_flag),
        .overflow_err  (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N*DW-1:0] sb_q [$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [N*DW-1:0] out_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = out_data[i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_vec(input int base, input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + 16*i + k);
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) check_eq("sb_unexpected_vec", out_vec(), '0);
            else check_eq("sb_vec", out_vec(), sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        res_valid = '0;
        for (int i = 0; i < N; i++) res_in[i] = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        sb_q.delete();
    endtask

    task automatic write_row(input logic [N-1:0] mask, input int base, input int k);
        for (int i = 0; i < N; i++) begin
            res_valid[i] = mask[i];
            res_in[i]    = DW'(base + 16*i + k);
        end
        tick();
        clear_in();
    endtask

    task automatic write_lane(input int lane, input int val);
        res_valid[lane] = 1'b1;
        res_in[lane]    = DW'(val);
        tick();
        clear_in();
    endtask

    // Lane i receives word k at cycle k+i.
    task automatic skew_fill(input int base, input int rows, input bit chk_lat);
        for (int c = 0; c <= rows + N - 2; c++) begin
            for (int i = 0; i < N; i++) begin
                if (c - i >= 0 && c - i < rows) begin
                    res_valid[i] = 1'b1;
                    res_in[i]    = DW'(base + 16*i + (c - i));
                end
            end
            tick();
            clear_in();
            if (chk_lat && c == N-1) check_eq("lat_before_last_lane", out_valid, 1'b0);
            if (chk_lat && c == N) begin
                check_eq("lat_first_vec_valid", out_valid, 1'b1);
                check_eq("lat_no_complete_yet", complete_flag, 1'b0);
            end
        end
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("sb_drain_timeout", sb_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag, input int exp_cnt, input bit exp_cpl);
        check_eq({tag, "_out_valid"}, out_valid, 1'b0);
        check_eq({tag, "_vec_count"}, vec_count, exp_cnt);
        check_eq({tag, "_complete"}, complete_flag, exp_cpl);
        check_eq({tag, "_overflow"}, overflow_err, 1'b0);
        check_eq({tag, "_stall"}, drain_stall, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        clear_in();
        repeat (3) @(posedge clk);
        #1;
        check_quiet("rst_init", 0, 1'b0);
        check_eq("rst_init_data", out_vec(), '0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Writes in IDLE are ignored: enough to overflow if they were taken.
        for (int j = 0; j < 20; j++) write_row('1, 16'h0900, j);
        tick();
        check_quiet("idle_wr", 0, 1'b0);

        // Skewed fill with out_ready high.
        pulse_start();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) sb_q.push_back(exp_vec(0, k));
        skew_fill(0, 4, 1'b1);
        wait_sb(20);
        #1;
        check_eq("skew_vec_count", vec_count, 4);
        check_eq("skew_complete", complete_flag, 1'b1);

        // Writes in DONE are ignored.
        for (int j = 0; j < 20; j++) write_row('1, 16'h0A00, j);
        tick();
        check_quiet("done_wr", 4, 1'b1);

        // Backpressure: output held, lane 0 grows until drain_stall.
        pulse_start();
        out_ready = 1'b0;
        check_eq("bp_start_count", vec_count, 0);
        check_eq("bp_start_complete", complete_flag, 1'b0);
        for (int k = 0; k < 4; k++) sb_q.push_back(exp_vec(16'h0200, k));
        skew_fill(16'h0200, 4, 1'b0);
        check_eq("bp_valid", out_valid, 1'b1);
        for (int j = 0; j < 10; j++) begin
            if (j < 9) begin
                write_lane(0, 16'h0A00 + j);
                check_eq("bp_stall", drain_stall, (3 + j + 1) >= 12);
            end else begin
                tick();
            end
            check_eq("bp_hold", out_vec(), exp_vec(16'h0200, 0));
        end
        out_ready = 1'b1;
        wait_sb(30);
        #1;
        check_eq("bp_vec_count", vec_count, 4);
        check_eq("bp_complete", complete_flag, 1'b1);
        check_eq("bp_stall_after", drain_stall, 1'b0);

        // Overflow on lane 0: the 17th word must be dropped.
        pulse_start();
        out_ready = 1'b0;
        for (int j = 0; j < 17; j++) begin
            write_lane(0, 16'h0300 + j);
            if (j == 15) begin
                check_eq("ovf_not_yet", overflow_err, 1'b0);
                check_eq("ovf_stall", drain_stall, 1'b1);
            end
            if (j == 16) check_eq("ovf_set", overflow_err, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(exp_vec(16'h0300, k));
            write_row(4'hE, 16'h0300, k);
        end
        out_ready = 1'b1;
        wait_sb(20);
        check_eq("ovf_sticky", overflow_err, 1'b1);
        pulse_start();
        check_eq("ovf_cleared", overflow_err, 1'b0);

        // start collides with a write and an accept.
        out_ready = 1'b0;
        write_row('1, 16'h0400, 0);
        write_row('1, 16'h0400, 1);
        check_eq("col_valid_before", out_valid, 1'b1);
        mon_en = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            res_valid[i] = 1'b1;
            res_in[i]    = 16'h04FF;
        end
        tick();
        start = 1'b0;
        clear_in();
        sb_q.delete();
        check_quiet("col", 0, 1'b0);
        mon_en = 1'b1;
        sb_q.push_back(exp_vec(16'h0500, 0));
        write_row('1, 16'h0500, 0);
        wait_sb(10);
        tick();
        tick();
        check_eq("col_no_leftover", out_valid, 1'b0);
        check_eq("col_vec_count", vec_count, 1);

        // Reset mid-DRAIN with buffered data, overflow and stall all active.
        out_ready = 1'b0;
        for (int j = 0; j < 17; j++) write_lane(0, 16'h0700 + j);
        write_row('1, 16'h0600, 0);
        tick();
        check_eq("mid_valid", out_valid, 1'b1);
        check_eq("mid_overflow", overflow_err, 1'b1);
        check_eq("mid_stall", drain_stall, 1'b1);
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid", 0, 1'b0);
        check_eq("rst_mid_data", out_vec(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        write_row('1, 16'h0B00, 0);
        tick();
        check_quiet("rst_idle", 0, 1'b0);
        mon_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
